spi_master_xfer: RTL and testbench
==================================

// Module: spi_master_xfer
// PURPOSE
//  Single-slave SPI master engine (mode 0, MSB first) that drives sck/ss/mosi and samples
//  miso for the bit-reversal SPI slave peripheral on the NPC perip bus. A simple
//  valid/ready command port issues one frame of up to MAXLEN bits; the captured miso bits
//  return on a response port. It sits between the bus-side register bridge and the slave.
// PARAMETERS
//  DIV     2    system clocks per sck half-period; legal range >=1
//  MAXLEN  32   maximum frame length in bits; sizes req_data/rsp_data
// PORTS
//  clock      in   1              system clock; all logic on posedge
//  reset_n    in   1              asynchronous, active-low reset
//  req_valid  in   1              frame request valid
//  req_ready  out  1              engine idle; request accepted when valid&&ready
//  req_len    in   $clog2(MAXLEN)+1  bit count, 1..MAXLEN; 0 is treated as 1
//  req_data   in   MAXLEN         tx bits; bit [req_len-1] is sent first
//  rsp_valid  out  1              one-cycle pulse: frame complete
//  rsp_data   out  MAXLEN         rx bits; last sampled in bit 0, upper unused bits 0
//  sck        out  1              SPI clock, idle low
//  ss         out  1              slave select, active low, idle high
//  mosi       out  1              master out; idle high
//  miso       in   1              slave out
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, sck=0, ss=1, mosi=1.
//  States: IDLE -> SETUP -> HIGH <-> LOW -> HOLD -> IDLE. Phase counter counts DIV clocks.
//  IDLE: req_ready=1. On accept: latch len/data, ss<=0, mosi<=first bit, cnt<=0, go SETUP.
//  SETUP: sck=0 for DIV clocks (mosi setup), then sck<=1, sample miso, go HIGH.
//  HIGH: after DIV clocks, sck<=0; if bits_done==len go HOLD, else mosi<=next bit, go LOW.
//  LOW: after DIV clocks, sck<=1, sample miso, bits_done++, go HIGH.
//  Sampling: miso is sampled on the system edge that drives sck 0->1, i.e. the value
//   the slave held during the preceding low phase; rx shifts left, new bit in LSB.
//  HOLD: sck=0, ss=0 for DIV clocks, then ss<=1, mosi<=1, rsp_valid<=1 (1 cycle),
//   rsp_data<=rx, go IDLE. req_ready is 1 again on the cycle rsp_valid is high.
//  Frame latency accept->rsp_valid = DIV*(2*len+1)+1 clocks; ss low for
//   DIV*(2*len+1) clocks; exactly len sck rising edges per frame.
//  req_ready=0 from accept until rsp_valid; inputs are ignored while busy
//   (no queueing). A request asserted in the rsp_valid cycle is accepted that cycle.
//  rsp_data holds its value until the next rsp_valid.
//  reset_n low mid-frame: immediate return to reset values (ss high, sck low);
//   the partial frame is discarded and no rsp_valid is produced.
//  len > MAXLEN is saturated to MAXLEN.
//  Unreachable state encodings return to IDLE with reset output values.
// STRUCTURE
//  spi_master_pkg: state enum (IDLE,SETUP,HIGH,LOW,HOLD), LEN_W = $clog2(MAXLEN)+1,
//   default DIV/MAXLEN constants.
//  Sub-module spi_clkgen: DIV phase counter producing a one-cycle 'tick' at the end of
//   each half-period; restarted by the FSM on accept.
//  Top: FSM, tx/rx shift registers, bit counter, output registers (all outputs registered).
// TESTING
//  1 Reset: hold reset_n low -> ss=1, sck=0, mosi=1, req_ready=1, rsp_valid=0;
//    release mid-frame after 5 edges -> outputs return to idle, no rsp_valid.
//  2 Loopback miso=mosi, DIV=1, len=8, data=0xA5 -> rsp_data=0xA5, 8 sck rises,
//    rsp_valid exactly 18 clocks after accept.
//  3 bitrev slave model, len=17, data={8'b1101_0010,9'b0}; tx 0xD2 -> rsp_data[7:0]=0xD2,
//    matching the slave's MSB-first replay.
//  4 Back-to-back: req_valid held high with two frames (len=4, 0x9 then 0x6) -> second is
//    accepted in the rsp_valid cycle; ss deasserted for at least 1 clock between frames.
//  5 Boundaries: len=0 -> 1 sck edge; len=MAXLEN data=all 1s with miso=1 -> rsp_data
//    all 1s; len=MAXLEN+5 -> MAXLEN edges.
//  6 Busy protocol: change req_data and pulse req_valid mid-frame -> ignored;
//    sck high/low phase widths equal DIV=3 clocks throughout.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI master frame engine.
// The command port width is derived from the maximum frame length.
package spi_master_pkg;

  localparam int DEFAULT_DIV    = 2;
  localparam int DEFAULT_MAXLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Wide enough to hold the value MAXLEN itself, not just MAXLEN-1.
  function automatic int len_width(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: pulses tick on the last system clock of every DIV-clock phase.
// restart realigns the phase so the first half-period after accept is full length.
module spi_clkgen #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_W'(DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (restart || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// Mode-0, MSB-first SPI master: one frame of 1..MAXLEN bits per accepted request,
// miso captured on each sck rising edge and returned on a one-cycle response pulse.
module spi_master_xfer
  import spi_master_pkg::*;
#(
  parameter int   DIV    = DEFAULT_DIV,
  parameter int   MAXLEN = DEFAULT_MAXLEN,
  localparam int  LEN_W  = len_width(MAXLEN)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [MAXLEN-1:0] req_data,
  output logic              rsp_valid,
  output logic [MAXLEN-1:0] rsp_data,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [LEN_W-1:0]  bits_reg, bits_next;
  logic [MAXLEN-1:0] tx_reg, tx_next;
  logic [MAXLEN-1:0] rx_reg, rx_next;
  logic              sck_reg, sck_next;
  logic              ss_reg, ss_next;
  logic              mosi_reg, mosi_next;
  logic              ready_reg, ready_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [MAXLEN-1:0] rsp_data_reg, rsp_data_next;

  logic              accept;
  logic              tick;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  tx_shamt;
  logic [MAXLEN-1:0] tx_aligned;
  logic [MAXLEN-1:0] rx_shift;

  assign accept = (state_reg == IDLE) && req_valid;

  spi_clkgen #(
    .DIV (DIV)
  ) u_clkgen (
    .clock   (clock),
    .reset_n (reset_n),
    .restart (accept),
    .tick    (tick)
  );

  // A zero length still sends one bit; oversize requests clip to the register width.
  always_comb begin
    len_eff = req_len;
    if (req_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (req_len > LEN_W'(MAXLEN)) begin
      len_eff = LEN_W'(MAXLEN);
    end
  end

  // Left-justify the frame so the first bit to send always sits in the MSB.
  assign tx_shamt   = LEN_W'(MAXLEN) - len_eff;
  assign tx_aligned = req_data << tx_shamt;
  assign rx_shift   = (rx_reg << 1) | MAXLEN'(miso);

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    bits_next      = bits_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    sck_next       = sck_reg;
    ss_next        = ss_reg;
    mosi_next      = mosi_reg;
    ready_next     = ready_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;

    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (req_valid) begin
          len_next   = len_eff;
          bits_next  = LEN_W'(1);
          tx_next    = tx_aligned << 1;
          mosi_next  = tx_aligned[MAXLEN-1];
          rx_next    = '0;
          ss_next    = 1'b0;
          ready_next = 1'b0;
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (tick) begin
          sck_next   = 1'b1;
          rx_next    = rx_shift;
          state_next = HIGH;
        end
      end

      HIGH: begin
        if (tick) begin
          sck_next = 1'b0;
          if (bits_reg == len_reg) begin
            state_next = HOLD;
          end else begin
            mosi_next  = tx_reg[MAXLEN-1];
            tx_next    = tx_reg << 1;
            state_next = LOW;
          end
        end
      end

      LOW: begin
        if (tick) begin
          sck_next   = 1'b1;
          rx_next    = rx_shift;
          bits_next  = bits_reg + LEN_W'(1);
          state_next = HIGH;
        end
      end

      HOLD: begin
        if (tick) begin
          ss_next        = 1'b1;
          mosi_next      = 1'b1;
          rsp_valid_next = 1'b1;
          rsp_data_next  = rx_reg;
          ready_next     = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        sck_next   = 1'b0;
        ss_next    = 1'b1;
        mosi_next  = 1'b1;
        ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      bits_reg      <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      sck_reg       <= 1'b0;
      ss_reg        <= 1'b1;
      mosi_reg      <= 1'b1;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      bits_reg      <= bits_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      sck_reg       <= sck_next;
      ss_reg        <= ss_next;
      mosi_reg      <= mosi_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign sck       = sck_reg;
  assign ss        = ss_reg;
  assign mosi      = mosi_reg;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: a DIV=1 and a DIV=3 instance share stimulus, selected by sel;
// expected responses go into a scoreboard queue and are popped when rsp_valid fires.
module tb_spi_master_xfer;

  localparam int MAXLEN = 32;
  localparam int LEN_W  = 6;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic [LEN_W-1:0]  req_len;
  logic [MAXLEN-1:0] req_data;
  logic              sel;
  int                miso_mode;
  logic              miso_const;

  logic              ready_a, rsp_valid_a, sck_a, ss_a, mosi_a, miso_a;
  logic              ready_b, rsp_valid_b, sck_b, ss_b, mosi_b, miso_b;
  logic [MAXLEN-1:0] rsp_data_a, rsp_data_b;

  logic              req_ready, rsp_valid, sck, ss, mosi;
  logic [MAXLEN-1:0] rsp_data;

  logic [7:0]        sl_byte = '0;
  int                sl_cnt = 0;
  logic              sl_prev = 1'b0;
  logic              sl_miso = 1'b0;

  int                n_checks = 0;
  int                n_fail = 0;
  int                rsp_cnt = 0;
  logic [31:0]       exp_q[$];

  always #5 clock = ~clock;

  spi_master_xfer #(.DIV(1), .MAXLEN(MAXLEN)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid & ~sel), .req_ready(ready_a),
    .req_len(req_len), .req_data(req_data), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .sck(sck_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a)
  );

  spi_master_xfer #(.DIV(3), .MAXLEN(MAXLEN)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid & sel), .req_ready(ready_b),
    .req_len(req_len), .req_data(req_data), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .sck(sck_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b)
  );

  assign req_ready = sel ? ready_b     : ready_a;
  assign rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_data  = sel ? rsp_data_b  : rsp_data_a;
  assign sck       = sel ? sck_b       : sck_a;
  assign ss        = sel ? ss_b        : ss_a;
  assign mosi      = sel ? mosi_b      : mosi_a;

  // miso source: 0 constant, 1 loopback of the instance's own mosi, 2 bit-replay slave
  assign miso_a = (miso_mode == 1) ? mosi_a : (miso_mode == 2) ? sl_miso : miso_const;
  assign miso_b = (miso_mode == 1) ? mosi_b : (miso_mode == 2) ? sl_miso : miso_const;

  // Slave: captures the first 8 bits, skips one bit, then replays them MSB first.
  always @(negedge clock) begin
    if (ss) begin
      sl_cnt  <= 0;
      sl_miso <= 1'b0;
    end else begin
      if (sck && !sl_prev) begin
        if (sl_cnt < 8) sl_byte <= {sl_byte[6:0], mosi};
        sl_cnt <= sl_cnt + 1;
      end
      if (!sck && sl_prev && sl_cnt >= 9 && sl_cnt <= 16) sl_miso <= sl_byte[16 - sl_cnt];
    end
    sl_prev <= sck;
  end

  always @(negedge clock) begin
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic do_frame(input int len, input logic [31:0] data, input int poke_at,
                          output int lat, output int rises, output int ss_low,
                          output int hi_min, output int hi_max, output int lo_min,
                          output int lo_max, output logic [31:0] got, output bit timed_out);
    int   wait_cnt;
    int   run;
    logic lvl;
    logic prev;
    wait_cnt = 0; lat = 0; rises = 0; ss_low = 0; got = '0; timed_out = 1'b0;
    hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
    while (!req_ready && wait_cnt < 200) begin
      @(negedge clock);
      wait_cnt++;
    end
    if (!req_ready) begin
      timed_out = 1'b1;
      return;
    end
    req_len   = LEN_W'(len);
    req_data  = data;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1; run = 0; lvl = 1'b0; prev = 1'b0;
    while (1) begin
      if (lat == poke_at) begin
        req_data  = ~data;
        req_valid = 1'b1;
      end else if (lat == poke_at + 1) begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        got = rsp_data;
        if (run > 0) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        break;
      end
      if (!ss) begin
        ss_low++;
        if (sck && !prev) rises++;
        if (sck == lvl) begin
          run++;
        end else begin
          if (lvl) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
          end else begin
            if (run < lo_min) lo_min = run;
            if (run > lo_max) lo_max = run;
          end
          lvl = sck;
          run = 1;
        end
      end
      prev = sck;
      if (lat >= 1000) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clock);
      lat++;
    end
    req_valid = 1'b0;
    $display("frame: len=%0d data=%08h rsp=%08h latency=%0d sck_rises=%0d", len, data, got, lat, rises);
  endtask

  task automatic test_reset();
    int   base;
    logic ss_seen_low;
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++; if (ss !== 1'b1) begin n_fail++; $display("FAIL reset_ss: got %b expected 1", ss); end
    n_checks++; if (sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b expected 0", sck); end
    n_checks++; if (mosi !== 1'b1) begin n_fail++; $display("FAIL reset_mosi: got %b expected 1", mosi); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    reset_n = 1'b1;
    @(negedge clock);
    miso_mode = 1;
    req_len = LEN_W'(8); req_data = 32'hA5; req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++; if (ss !== 1'b0) begin n_fail++; $display("FAIL midframe_ss: got %b expected 0", ss); end
    base = rsp_cnt;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({ss, sck, mosi, req_ready} !== 4'b1011) begin
      n_fail++; $display("FAIL async_reset_outputs: got ss,sck,mosi,ready=%b expected 1011", {ss, sck, mosi, req_ready});
    end
    @(negedge clock);
    reset_n = 1'b1;
    ss_seen_low = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (!ss) ss_seen_low = 1'b1;
    end
    n_checks++; if (rsp_cnt !== base) begin n_fail++; $display("FAIL aborted_no_rsp: got %0d pulses expected %0d", rsp_cnt, base); end
    n_checks++; if (ss_seen_low !== 1'b0) begin n_fail++; $display("FAIL aborted_ss_idle: got ss low seen=%b expected 0", ss_seen_low); end
  endtask

  task automatic test_loopback();
    int lat, rises, ss_low, h0, h1, l0, l1;
    logic [31:0] got, exp_v;
    bit to;
    sel = 1'b0; miso_mode = 1;
    exp_q.push_back(32'h0000_00A5);
    do_frame(8, 32'hA5, -10, lat, rises, ss_low, h0, h1, l0, l1, got, to);
    exp_v = exp_q.pop_front();
    n_checks++; if (to) begin n_fail++; $display("FAIL loop_timeout: got timeout expected rsp_valid"); end
    n_checks++; if (got !== exp_v) begin n_fail++; $display("FAIL loop_data: got %h expected %h", got, exp_v); end
    n_checks++; if (rises != 8) begin n_fail++; $display("FAIL loop_rises: got %0d expected 8", rises); end
    n_checks++; if (lat != 18) begin n_fail++; $display("FAIL loop_latency: got %0d expected 18", lat); end
    n_checks++; if (ss_low != 17) begin n_fail++; $display("FAIL loop_ss_low: got %0d expected 17", ss_low); end
  endtask

  task automatic test_bitrev();
    int lat, rises, ss_low, h0, h1, l0, l1;
    logic [31:0] got, exp_v;
    bit to;
    sel = 1'b0; miso_mode = 2;
    exp_q.push_back(32'h0000_00D2);
    do_frame(17, 32'h0001_A400, -10, lat, rises, ss_low, h0, h1, l0, l1, got, to);
    exp_v = exp_q.pop_front();
    n_checks++; if (to || got !== exp_v) begin n_fail++; $display("FAIL bitrev_data: got %h (timeout=%0d) expected %h", got, to, exp_v); end
    n_checks++; if (rises != 17) begin n_fail++; $display("FAIL bitrev_rises: got %0d expected 17", rises); end
    n_checks++; if (lat != 36) begin n_fail++; $display("FAIL bitrev_latency: got %0d expected 36", lat); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [31:0] exp_v;
    sel = 1'b0; miso_mode = 1;
    exp_q.push_back(32'h9);
    exp_q.push_back(32'h6);
    req_len = LEN_W'(4); req_data = 32'h9; req_valid = 1'b1;
    @(negedge clock);
    req_data = 32'h6;
    lat1 = 1;
    while (!rsp_valid && lat1 < 100) begin
      @(negedge clock);
      lat1++;
    end
    exp_v = exp_q.pop_front();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_v) begin n_fail++; $display("FAIL b2b_first_data: got %h valid=%b expected %h", rsp_data, rsp_valid, exp_v); end
    n_checks++; if (lat1 != 10) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 10", lat1); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_rsp: got %b expected 1", req_ready); end
    n_checks++; if (ss !== 1'b1) begin n_fail++; $display("FAIL b2b_ss_gap: got %b expected 1", ss); end
    $display("frame: len=4 data=00000009 rsp=%08h latency=%0d", rsp_data, lat1);
    @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if (ss !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got ss=%b expected 0", ss); end
    lat2 = 1;
    while (!rsp_valid && lat2 < 100) begin
      @(negedge clock);
      lat2++;
    end
    exp_v = exp_q.pop_front();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_v) begin n_fail++; $display("FAIL b2b_second_data: got %h valid=%b expected %h", rsp_data, rsp_valid, exp_v); end
    n_checks++; if (lat2 != 10) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 10", lat2); end
    $display("frame: len=4 data=00000006 rsp=%08h latency=%0d", rsp_data, lat2);
    @(negedge clock);
  endtask

  task automatic test_boundaries();
    int lat, rises, ss_low, h0, h1, l0, l1;
    logic [31:0] got, exp_v;
    bit to;
    sel = 1'b0; miso_mode = 0; miso_const = 1'b1;
    exp_q.push_back(32'h1);
    do_frame(0, 32'h0, -10, lat, rises, ss_low, h0, h1, l0, l1, got, to);
    exp_v = exp_q.pop_front();
    n_checks++; if (to || got !== exp_v) begin n_fail++; $display("FAIL len0_data: got %h (timeout=%0d) expected %h", got, to, exp_v); end
    n_checks++; if (rises != 1) begin n_fail++; $display("FAIL len0_rises: got %0d expected 1", rises); end
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL len0_latency: got %0d expected 4", lat); end
    exp_q.push_back(32'hFFFF_FFFF);
    do_frame(MAXLEN, 32'hFFFF_FFFF, -10, lat, rises, ss_low, h0, h1, l0, l1, got, to);
    exp_v = exp_q.pop_front();
    n_checks++; if (to || got !== exp_v) begin n_fail++; $display("FAIL maxlen_data: got %h (timeout=%0d) expected %h", got, to, exp_v); end
    n_checks++; if (rises != MAXLEN) begin n_fail++; $display("FAIL maxlen_rises: got %0d expected %0d", rises, MAXLEN); end
    miso_mode = 1;
    exp_q.push_back(32'hDEAD_BEEF);
    do_frame(MAXLEN + 5, 32'hDEAD_BEEF, -10, lat, rises, ss_low, h0, h1, l0, l1, got, to);
    exp_v = exp_q.pop_front();
    n_checks++; if (to || got !== exp_v) begin n_fail++; $display("FAIL oversize_data: got %h (timeout=%0d) expected %h", got, to, exp_v); end
    n_checks++; if (rises != MAXLEN) begin n_fail++; $display("FAIL oversize_rises: got %0d expected %0d", rises, MAXLEN); end
    n_checks++; if (lat != 2 * MAXLEN + 2) begin n_fail++; $display("FAIL oversize_latency: got %0d expected %0d", lat, 2 * MAXLEN + 2); end
  endtask

  task automatic test_busy();
    int lat, rises, ss_low, hi_min, hi_max, lo_min, lo_max, base;
    logic [31:0] got, exp_v;
    logic ss_seen_low;
    bit to;
    sel = 1'b1; miso_mode = 1;
    exp_q.push_back(32'h3C);
    do_frame(8, 32'h3C, 10, lat, rises, ss_low, hi_min, hi_max, lo_min, lo_max, got, to);
    exp_v = exp_q.pop_front();
    n_checks++; if (to || got !== exp_v) begin n_fail++; $display("FAIL busy_data: got %h (timeout=%0d) expected %h", got, to, exp_v); end
    n_checks++; if (rises != 8) begin n_fail++; $display("FAIL busy_rises: got %0d expected 8", rises); end
    n_checks++; if (lat != 52) begin n_fail++; $display("FAIL busy_latency: got %0d expected 52", lat); end
    n_checks++; if (hi_min != 3 || hi_max != 3) begin n_fail++; $display("FAIL high_width: got min %0d max %0d expected 3", hi_min, hi_max); end
    n_checks++; if (lo_min != 3 || lo_max != 3) begin n_fail++; $display("FAIL low_width: got min %0d max %0d expected 3", lo_min, lo_max); end
    @(negedge clock);
    base = rsp_cnt;
    ss_seen_low = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (!ss) ss_seen_low = 1'b1;
    end
    n_checks++; if (rsp_cnt !== base || ss_seen_low !== 1'b0) begin
      n_fail++; $display("FAIL busy_no_queue: got extra rsp=%0d ss_low_seen=%b expected 0 and 0", rsp_cnt - base, ss_seen_low);
    end
    sel = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_len = '0; req_data = '0;
    sel = 1'b0; miso_mode = 0; miso_const = 1'b0;
    test_reset();
    test_loopback();
    test_bitrev();
    test_back_to_back();
    test_boundaries();
    test_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
